y_seq_alu: RTL and testbench
============================

Y_SEQ_ALU -- requirements
Module: y_seq_alu

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin an operation; sampled only when ready=1.
REQ-005 SHALL have port: op  input  3  operation select, captured with start.
REQ-006 SHALL have port: a  input  WIDTH  operand A, captured with start.
REQ-007 SHALL have port: b  input  WIDTH  operand B, captured with start.
REQ-008 SHALL have port: ready  output  1  high when block can accept start.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking valid result.
REQ-010 SHALL have port: z  output  WIDTH  registered result.
REQ-011 SHALL have port: zero  output  1  registered, 1 when z==0.
REQ-012 SHALL have port: cout  output  1  registered carry-out of add/sub.
REQ-013 SHALL have port: ovf  output  1  registered signed/width overflow flag.

Function
REQ-014 SHALL decode op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 XOR, 101 NOR, 011 MUL.
REQ-015 SHALL implement FSM states IDLE, MUL, DONE; ready=1 only in IDLE.
REQ-016 SHALL accept an operation on an edge where state=IDLE and start=1; a, b, op captured on that edge.
REQ-017 SHALL, for non-MUL ops, load z/flags and go IDLE->DONE on the accepting edge (latency 1 cycle).
REQ-018 SHALL, for MUL, go IDLE->MUL on accept, perform one shift-add step (unsigned, 2*WIDTH product) per edge for WIDTH edges, load z/flags and go MUL->DONE on the WIDTH-th step edge (latency WIDTH cycles).
REQ-019 SHALL hold done=1 for exactly the DONE cycle, then go DONE->IDLE unconditionally.
REQ-020 SHALL ignore start while ready=0 (MUL or DONE); no queuing.
REQ-021 SHALL hold z, zero, cout, ovf stable from DONE until the next result load.
REQ-022 SHALL compute ADD as a+b and SUB as a+~b+1, all modulo 2^WIDTH; cout = carry out of bit WIDTH-1.
REQ-023 SHALL set ovf for ADD/SUB to signed overflow (operand signs equal after B inversion, result sign differs).
REQ-024 SHALL produce SLT z = {WIDTH-1 zeros, lt}, lt = signed a<b, correct even when a-b overflows (lt=a[MSB] when signs differ).
REQ-025 SHALL produce MUL z = low WIDTH bits of unsigned a*b; ovf=1 iff upper WIDTH product bits nonzero; cout=0.
REQ-026 SHALL drive cout=0 and ovf=0 for AND, OR, XOR, NOR, SLT.
REQ-027 SHALL compute zero from the loaded z value in the same edge (zero valid whenever z valid).

Reset
REQ-028 SHALL, when rst=1 on an edge, force state=IDLE, z=0, zero=1, cout=0, ovf=0, done=0, ready=1 after that edge.
REQ-029 SHALL give rst priority over start and over any in-progress MUL; partial product discarded, no done pulse.
REQ-030 SHALL ignore start on an edge where rst=1.

Verification (WIDTH=32)
REQ-031 SHALL test ADD: a=0x7FFFFFFF, b=1, start -> next cycle done=1, z=0x80000000, ovf=1, cout=0, zero=0.
REQ-032 SHALL test SUB: a=5, b=5 -> z=0, zero=1, cout=1, ovf=0; SLT a=0x80000000, b=1 -> z=1, ovf=0.
REQ-033 SHALL test MUL: a=0x00010000, b=0x00010000 -> ready=0 for 32 cycles, done on 32nd cycle after accept, z=0, zero=1, ovf=1; a=1234, b=5678 -> z=7006652, ovf=0.
REQ-034 SHALL test start asserted during MUL and DONE -> ignored, result of first op unchanged, exactly one done pulse.
REQ-035 SHALL test rst=1 at MUL step 10 -> next cycle ready=1, z=0, zero=1, no done pulse; new ADD 2+3 then returns z=5.
REQ-036 SHALL test back-to-back AND: start held high continuously with a=0xF0F0F0F0, b=0xFF00FF00 -> done every 2nd cycle, z=0xF000F000.

Source files
------------

// File: rtl/y_seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus a WIDTH-step shift-add multiplier.
// Results and flags are registered and held until the next operation completes.
module y_seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             zero,
    output logic             cout,
    output logic             ovf
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_MUL = 3'b011,
        OP_XOR = 3'b100,
        OP_NOR = 3'b101,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_sum;
    logic [WIDTH-1:0]   b_inv;
    logic               lt;
    logic [WIDTH-1:0]   alu_z;
    logic               alu_cout;
    logic               alu_ovf;
    logic [2*WIDTH-1:0] mul_prod;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        b_inv    = ~b;
        add_sum  = {1'b0, a} + {1'b0, b};
        sub_sum  = {1'b0, a} + {1'b0, b_inv} + {{WIDTH{1'b0}}, 1'b1};
        // When signs differ the subtraction may overflow; the sign of a alone decides.
        lt       = (a[MSB] != b[MSB]) ? a[MSB] : sub_sum[MSB];
        alu_z    = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (op)
            OP_AND: alu_z = a & b;
            OP_OR:  alu_z = a | b;
            OP_XOR: alu_z = a ^ b;
            OP_NOR: alu_z = ~(a | b);
            OP_SLT: alu_z = {{(WIDTH-1){1'b0}}, lt};
            OP_ADD: begin
                alu_z    = add_sum[MSB:0];
                alu_cout = add_sum[WIDTH];
                alu_ovf  = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_z    = sub_sum[MSB:0];
                alu_cout = sub_sum[WIDTH];
                alu_ovf  = (a[MSB] == b_inv[MSB]) && (sub_sum[MSB] != a[MSB]);
            end
            default: alu_z = '0;
        endcase
        mul_prod = acc + (mplier[0] ? mcand : '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            z      <= '0;
            zero   <= 1'b1;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ready <= 1'b0;
                        if (op == OP_MUL) begin
                            // The accepting edge performs the first multiply step.
                            state  <= S_MUL;
                            acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                            mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
                            mplier <= {1'b0, b[MSB:1]};
                            cnt    <= CW'(1);
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            z     <= alu_z;
                            zero  <= (alu_z == '0);
                            cout  <= alu_cout;
                            ovf   <= alu_ovf;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= mul_prod;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        z     <= mul_prod[MSB:0];
                        zero  <= (mul_prod[MSB:0] == '0);
                        cout  <= 1'b0;
                        ovf   <= |mul_prod[2*WIDTH-1:WIDTH];
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y_seq_alu.sv
// Directed self-checking bench for y_seq_alu at WIDTH=32: a vector table for
// single-cycle ops plus hand-written multiply, start-ignore, reset and back-to-back sequences.
module tb_y_seq_alu;

    localparam int W = 32;

    localparam logic [2:0] AND_OP = 3'b000;
    localparam logic [2:0] OR_OP  = 3'b001;
    localparam logic [2:0] ADD_OP = 3'b010;
    localparam logic [2:0] MUL_OP = 3'b011;
    localparam logic [2:0] XOR_OP = 3'b100;
    localparam logic [2:0] NOR_OP = 3'b101;
    localparam logic [2:0] SUB_OP = 3'b110;
    localparam logic [2:0] SLT_OP = 3'b111;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] z;
    logic         zero;
    logic         cout;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_z;
        logic         exp_zero;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[14];

    y_seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .z     (z),
        .zero  (zero),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        check({v.name, " ready"}, 64'(ready), 64'(1));
        start = 1'b1;
        op    = v.op;
        a     = v.a;
        b     = v.b;
        step();
        start = 1'b0;
        check({v.name, " done"}, 64'(done), 64'(1));
        check({v.name, " z"},    64'(z),    64'(v.exp_z));
        check({v.name, " zero"}, 64'(zero), 64'(v.exp_zero));
        check({v.name, " cout"}, 64'(cout), 64'(v.exp_cout));
        check({v.name, " ovf"},  64'(ovf),  64'(v.exp_ovf));
        step();
        check({v.name, " done low"}, 64'(done), 64'(0));
        check({v.name, " z held"},   64'(z),    64'(v.exp_z));
    endtask

    // Multiply with optional start held high (different op/operands) through MUL and DONE.
    task automatic run_mul(input string name, input logic [W-1:0] ma, input logic [W-1:0] mb,
                           input logic [W-1:0] exp_z, input logic exp_ovf, input bit hold_start);
        int first_done = 0;
        int n_done     = 0;
        int low_cnt    = 0;
        logic [W-1:0] z_at = '0;
        logic zero_at = 1'b0, ovf_at = 1'b0, cout_at = 1'b1;
        check({name, " ready"}, 64'(ready), 64'(1));
        start = 1'b1;
        op    = MUL_OP;
        a     = ma;
        b     = mb;
        step();
        if (hold_start) begin
            op = ADD_OP;
            a  = 32'd1;
            b  = 32'd1;
        end else begin
            start = 1'b0;
        end
        for (int k = 1; k <= 40; k++) begin
            if (!ready) low_cnt++;
            if (done) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = k;
                    z_at    = z;
                    zero_at = zero;
                    ovf_at  = ovf;
                    cout_at = cout;
                end
            end
            if (k == 32) start = 1'b0;
            step();
        end
        check({name, " done cycle"},   64'(first_done), 64'(32));
        check({name, " done pulses"},  64'(n_done),     64'(1));
        check({name, " busy cycles"},  64'(low_cnt),    64'(32));
        check({name, " z"},            64'(z_at),       64'(exp_z));
        check({name, " zero"},         64'(zero_at),    64'(exp_z == '0));
        check({name, " ovf"},          64'(ovf_at),     64'(exp_ovf));
        check({name, " cout"},         64'(cout_at),    64'(0));
        check({name, " z held"},       64'(z),          64'(exp_z));
    endtask

    initial begin
        int n_done;

        vecs[0]  = '{"add_ovf",   ADD_OP, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{"sub_eq",    SUB_OP, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{"slt_neg",   SLT_OP, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{"and",       AND_OP, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{"or",        OR_OP,  32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"xor",       XOR_OP, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{"nor_ones",  NOR_OP, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"nor_zero",  NOR_OP, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{"add_carry", ADD_OP, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{"sub_ovf",   SUB_OP, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{"slt_vovf",  SLT_OP, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{"slt_pos",   SLT_OP, 32'h00000003, 32'h00000005, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{"slt_same",  SLT_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{"sub_borrow",SUB_OP, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b1;
        op    = ADD_OP;
        a     = 32'd7;
        b     = 32'd9;
        step();
        step();
        check("reset ready", 64'(ready), 64'(1));
        check("reset done",  64'(done),  64'(0));
        check("reset z",     64'(z),     64'(0));
        check("reset zero",  64'(zero),  64'(1));
        check("reset cout",  64'(cout),  64'(0));
        check("reset ovf",   64'(ovf),   64'(0));
        rst   = 1'b0;
        start = 1'b0;
        step();

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        run_mul("mul_2p32", 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0);
        run_mul("mul_small", 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0);
        run_mul("mul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0);
        run_mul("mul_hold", 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b1);

        // Reset on the tenth multiply step: no result, no done pulse.
        start = 1'b1;
        op    = MUL_OP;
        a     = 32'd1234;
        b     = 32'd5678;
        step();
        start = 1'b0;
        for (int k = 1; k < 9; k++) step();
        check("mulrst busy", 64'(ready), 64'(0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mulrst ready", 64'(ready), 64'(1));
        check("mulrst z",     64'(z),     64'(0));
        check("mulrst zero",  64'(zero),  64'(1));
        check("mulrst done",  64'(done),  64'(0));
        n_done = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) n_done++;
            step();
        end
        check("mulrst no pulse", 64'(n_done), 64'(0));
        run_vec('{"add_after_rst", ADD_OP, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0});

        // Back-to-back AND with start held: accepted every second edge.
        start = 1'b1;
        op    = AND_OP;
        a     = 32'hF0F0F0F0;
        b     = 32'hFF00FF00;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("b2b done %0d", k), 64'(done), 64'((k % 2) == 0));
            check($sformatf("b2b z %0d", k),    64'(z),    64'(32'hF000F000));
        end
        start = 1'b0;
        step();
        step();
        check("b2b idle", 64'(ready), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
